// File: rtl/register_file.sv
// register_file: 2**ADDR_W x WIDTH register file, two read ports, one write port, with a write counter.
// Latency: reads are combinational (zero cycles); a write is visible right after the clk edge that commits it.
// Backpressure: none; a write offered with RegWrite=1 is always taken unless it targets $0 or reset is high.
//
// Ports:
//   clk         - single clock, all state changes on its rising edge
//   reset       - asynchronous, active-high; clears every register and WriteCount
//   RegWrite    - write enable
//   WriteReg    - destination register address
//   WriteData   - value to write
//   ReadReg1/2  - read addresses (rs / rt)
//   ReadData1/2 - contents of the addressed registers
//   WriteCount  - committed non-$0 writes since reset, saturating at 16'hFFFF
//
// Build option: define REGFILE_BYPASS_EN to forward a same-cycle write to a
// read port addressing the same register (write-before-read). Without it the
// read ports return the stored pre-edge value.

module register_file #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              RegWrite,
  input  logic [ADDR_W-1:0] WriteReg,
  input  logic [WIDTH-1:0]  WriteData,
  input  logic [ADDR_W-1:0] ReadReg1,
  input  logic [ADDR_W-1:0] ReadReg2,
  output logic [WIDTH-1:0]  ReadData1,
  output logic [WIDTH-1:0]  ReadData2,
  output logic [15:0]       WriteCount
);

  localparam int NREGS = 1 << ADDR_W;

  logic [WIDTH-1:0] regs [NREGS];
  logic [15:0]      wr_count;
  logic             commit;

  // A write only commits when enabled and not aimed at the hardwired-zero $0.
  assign commit = RegWrite && (WriteReg != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
      wr_count <= '0;
    end else if (commit) begin
      regs[WriteReg] <= WriteData;
      if (wr_count != 16'hFFFF) begin
        wr_count <= wr_count + 16'd1;
      end
    end
  end

  assign WriteCount = wr_count;

  // $0 is never written, but the read mux still forces zero so the
  // guarantee does not depend on the storage behind address 0.
  always_comb begin
    ReadData1 = regs[ReadReg1];
    if (ReadReg1 == '0) begin
      ReadData1 = '0;
    end
`ifdef REGFILE_BYPASS_EN
    // Forwarding is suppressed during reset so reads stay at zero.
    if (!reset && commit && (ReadReg1 == WriteReg)) begin
      ReadData1 = WriteData;
    end
`endif
  end

  always_comb begin
    ReadData2 = regs[ReadReg2];
    if (ReadReg2 == '0) begin
      ReadData2 = '0;
    end
`ifdef REGFILE_BYPASS_EN
    if (!reset && commit && (ReadReg2 == WriteReg)) begin
      ReadData2 = WriteData;
    end
`endif
  end

endmodule

// File: tb/tb_register_file.sv
// tb_register_file: self-checking bench for register_file.
// Directed scenarios followed by randomized traffic checked against an array model.
// Checks are immediate assertions; the summary line reports totals.

module tb_register_file;

  localparam int WIDTH  = 32;
  localparam int ADDR_W = 5;

  logic              clk;
  logic              reset;
  logic              RegWrite;
  logic [ADDR_W-1:0] WriteReg;
  logic [WIDTH-1:0]  WriteData;
  logic [ADDR_W-1:0] ReadReg1;
  logic [ADDR_W-1:0] ReadReg2;
  logic [WIDTH-1:0]  ReadData1;
  logic [WIDTH-1:0]  ReadData2;
  logic [15:0]       WriteCount;

  register_file #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .RegWrite  (RegWrite),
    .WriteReg  (WriteReg),
    .WriteData (WriteData),
    .ReadReg1  (ReadReg1),
    .ReadReg2  (ReadReg2),
    .ReadData1 (ReadData1),
    .ReadData2 (ReadData2),
    .WriteCount(WriteCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain array of register contents and an integer write tally.
  logic [WIDTH-1:0] model_mem [32];
  int               model_cnt;
  int               checks;
  int               failures;

  // Writes with an unknown destination are illegal.
  always @(posedge clk) begin
    if (RegWrite === 1'b1) begin
      assert (!$isunknown(WriteReg)) else $error("illegal X/Z on WriteReg during write");
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] exp_read(input logic [ADDR_W-1:0] a);
    if (reset) return '0;
    if (a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
    if (RegWrite && WriteReg != 0 && a == WriteReg) return WriteData;
`endif
    return model_mem[a];
  endfunction

  function automatic logic [31:0] exp_cnt();
    return {16'd0, model_cnt[15:0]};
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) model_mem[i] = '0;
    model_cnt = 0;
  endtask

  // One rising edge; the model commits what the inputs presented, then settle.
  task automatic tick();
    @(posedge clk);
    if (!reset && RegWrite && WriteReg != 0) begin
      model_mem[WriteReg] = WriteData;
      if (model_cnt < 65535) model_cnt++;
    end
    #1;
  endtask

  task automatic drive(input logic we, input logic [ADDR_W-1:0] wa, input logic [WIDTH-1:0] wd,
                       input logic [ADDR_W-1:0] r1, input logic [ADDR_W-1:0] r2);
    @(negedge clk);
    RegWrite  = we;
    WriteReg  = wa;
    WriteData = wd;
    ReadReg1  = r1;
    ReadReg2  = r2;
    #1;
  endtask

  task automatic check_reads(input string tag);
    check({tag, "_rd1"}, ReadData1, exp_read(ReadReg1));
    check({tag, "_rd2"}, ReadData2, exp_read(ReadReg2));
    check({tag, "_cnt"}, {16'd0, WriteCount}, exp_cnt());
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    reset     = 1'b1;
    RegWrite  = 1'b0;
    WriteReg  = '0;
    WriteData = '0;
    ReadReg1  = '0;
    ReadReg2  = '0;
    model_clear();

    // Reset state
    #3;
    ReadReg1 = 5'd5;
    ReadReg2 = 5'd31;
    #1;
    check("reset_rd1", ReadData1, 32'h0);
    check("reset_rd2", ReadData2, 32'h0);
    check("reset_cnt", {16'd0, WriteCount}, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // Load r5, then assert reset mid-cycle while a write to r5 is still offered
    drive(1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd5);
    tick();
    check("r5_loaded", ReadData1, 32'hDEADBEEF);
    @(negedge clk);
    #2;
    reset = 1'b1;
    model_clear();
    #1;
    check("async_rst_rd1", ReadData1, 32'h0);
    check("async_rst_cnt", {16'd0, WriteCount}, 32'h0);
    tick();
    check("rst_blocks_wr_rd1", ReadData1, 32'h0);
    check("rst_blocks_wr_cnt", {16'd0, WriteCount}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    tick();
    check("first_wr_after_rst", ReadData1, 32'hDEADBEEF);
    check("first_wr_after_rst_cnt", {16'd0, WriteCount}, exp_cnt());

    // Basic write/read on both ports
    drive(1'b1, 5'd7, 32'h12345678, 5'd1, 5'd2);
    tick();
    drive(1'b0, 5'd0, 32'h0, 5'd7, 5'd7);
    check("basic_rd1", ReadData1, 32'h12345678);
    check("basic_rd2", ReadData2, 32'h12345678);
    check("basic_cnt", {16'd0, WriteCount}, exp_cnt());

    // $0 protection
    drive(1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
    check_reads("r0_pre");
    tick();
    check("r0_post_rd1", ReadData1, 32'h0);
    check("r0_post_cnt", {16'd0, WriteCount}, exp_cnt());

    // Same-cycle read of the register being written
    drive(1'b1, 5'd3, 32'h1, 5'd0, 5'd0);
    tick();
    drive(1'b1, 5'd3, 32'h2, 5'd0, 5'd3);
`ifdef REGFILE_BYPASS_EN
    check("same_cycle_pre", ReadData2, 32'h2);
`else
    check("same_cycle_pre", ReadData2, 32'h1);
`endif
    tick();
    check("same_cycle_post", ReadData2, 32'h2);

    // Enable low over four edges
    drive(1'b0, 5'd9, 32'hA5A5A5A5, 5'd9, 5'd9);
    for (int i = 0; i < 4; i++) tick();
    check("we_low_rd1", ReadData1, 32'h0);
    check("we_low_cnt", {16'd0, WriteCount}, exp_cnt());

    // Randomized traffic against the model
    for (int i = 0; i < 300; i++) begin
      logic [ADDR_W-1:0] wa;
      logic [ADDR_W-1:0] r1;
      logic [ADDR_W-1:0] r2;
      wa = ($urandom_range(0, 7) == 0) ? 5'd0 : ADDR_W'($urandom_range(0, 31));
      r1 = ($urandom_range(0, 3) == 0) ? wa : ADDR_W'($urandom_range(0, 31));
      r2 = ($urandom_range(0, 3) == 0) ? wa : ADDR_W'($urandom_range(0, 31));
      drive(($urandom_range(0, 2) != 0), wa, $urandom, r1, r2);
      check_reads("rand_pre");
      tick();
      check_reads("rand_post");
    end

    // Saturation of WriteCount
    drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    force dut.wr_count = 16'hFFFE;
    #1;
    release dut.wr_count;
    model_cnt = 16'hFFFE;
    #1;
    check("sat_preload", {16'd0, WriteCount}, 32'h0000FFFE);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, ADDR_W'(10 + i), 32'hC0DE0000 + i, 5'd10, 5'd12);
      tick();
      check("sat_cnt", {16'd0, WriteCount}, exp_cnt());
    end
    check("sat_final", {16'd0, WriteCount}, 32'h0000FFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
